// File: rtl/cpu_pkg.sv
// Shared definitions for the vector CPU execute lanes: word type, opcodes,
// jump/memory subcodes and small decode helpers.
package cpu_pkg;

    typedef logic [15:0] word_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_MOVL = 4'h4;
    localparam logic [3:0] OP_MOVH = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_LDST = 4'h7;
    localparam logic [3:0] OP_VADD = 4'h8;
    localparam logic [3:0] OP_VSUB = 4'h9;
    localparam logic [3:0] OP_VMUL = 4'hA;
    localparam logic [3:0] OP_VDIV = 4'hB;
    localparam logic [3:0] OP_VLD  = 4'hC;
    localparam logic [3:0] OP_VST  = 4'hD;
    localparam logic [3:0] OP_VDOT = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [3:0] JMP_JZ  = 4'h0;
    localparam logic [3:0] JMP_JNZ = 4'h1;
    localparam logic [3:0] JMP_JS  = 4'h2;
    localparam logic [3:0] JMP_JNS = 4'h3;

    localparam logic [3:0] MEM_LD = 4'h0;
    localparam logic [3:0] MEM_ST = 4'h1;

    // Memory-class opcodes share the ld/st subcode in ins[7:4].
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LDST) || (op == OP_VLD) || (op == OP_VST);
    endfunction

    // Arithmetic ops read reg rb as operand X; everything else reads rt.
    function automatic logic uses_rb(input logic [3:0] op);
        return (op == OP_ADD)  || (op == OP_SUB)  || (op == OP_MUL)  || (op == OP_DIV)  ||
               (op == OP_VADD) || (op == OP_VSUB) || (op == OP_VMUL) || (op == OP_VDIV) ||
               (op == OP_VDOT);
    endfunction

    // A load takes its result from the memory bank instead of the ALU.
    function automatic logic is_load(input word_t ins);
        return is_mem_op(ins[15:12]) && (ins[7:4] == MEM_LD);
    endfunction

endpackage

// File: rtl/alu_compute.sv
// Combinational execute datapath: decodes the instruction word and produces
// the primary result and secondary (overflow/remainder/high/flag) word.
module alu_compute
    import cpu_pkg::*;
(
    input  word_t ins,
    input  word_t a,
    input  word_t x,
    output word_t result,
    output word_t overflow
);

    logic [16:0] sum_s;
    logic [16:0] diff_s;
    logic [31:0] prod_s;
    word_t       quot_s;
    word_t       rem_s;
    logic [3:0]  op_s;
    logic [3:0]  sub_s;
    logic        taken_s;

    assign op_s   = ins[15:12];
    assign sub_s  = ins[7:4];
    assign sum_s  = {1'b0, a} + {1'b0, x};
    assign diff_s = {1'b0, a} - {1'b0, x};
    assign prod_s = {16'h0000, a} * {16'h0000, x};
    // Divide by zero saturates the quotient and passes the dividend as remainder.
    assign quot_s = (x == 16'h0000) ? 16'hFFFF : (a / x);
    assign rem_s  = (x == 16'h0000) ? a        : (a % x);

    // Jump condition evaluated on operand X; unknown subcodes never branch.
    always_comb begin
        taken_s = 1'b0;
        case (sub_s)
            JMP_JZ:  taken_s = (x == 16'h0000);
            JMP_JNZ: taken_s = (x != 16'h0000);
            JMP_JS:  taken_s = x[15];
            JMP_JNS: taken_s = ~x[15];
            default: taken_s = 1'b0;
        endcase
    end

    // Opcode select for result and overflow words.
    always_comb begin
        result   = 16'h0000;
        overflow = 16'h0000;
        case (op_s)
            OP_ADD, OP_VADD: begin
                result   = sum_s[15:0];
                overflow = {15'h0000, sum_s[16]};
            end
            OP_SUB, OP_VSUB: begin
                result   = diff_s[15:0];
                overflow = {15'h0000, diff_s[16]};
            end
            OP_MUL, OP_VMUL: begin
                result   = prod_s[15:0];
                overflow = prod_s[31:16];
            end
            OP_DIV, OP_VDIV: begin
                result   = quot_s;
                overflow = rem_s;
            end
            OP_MOVL: begin
                result   = {{8{ins[11]}}, ins[11:4]};
                overflow = 16'h0000;
            end
            OP_MOVH: begin
                result   = {ins[11:4], x[7:0]};
                overflow = 16'h0000;
            end
            OP_JMP: begin
                result   = a;
                overflow = {15'h0000, taken_s};
            end
            OP_LDST, OP_VLD, OP_VST: begin
                // Loads are replaced by bank data in X2; only stores carry data here.
                if (sub_s == MEM_ST) begin
                    result   = x;
                    overflow = a;
                end else begin
                    result   = 16'h0000;
                    overflow = 16'h0000;
                end
            end
            OP_VDOT: begin
                result   = prod_s[15:0];
                overflow = 16'h0000;
            end
            default: begin
                result   = 16'h0000;
                overflow = 16'h0000;
            end
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage (X, X2) execute lane. X registers the presented instruction and
// operands; X2 registers the computed result plus the carried fields. Load
// results bypass the X2 register because bank data arrives during X2.
module alu_pipe
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [15:0] in_pc,
    input  logic [15:0] in_ins,
    input  logic [15:0] ra_val,
    input  logic [15:0] rx_val,
    input  logic [15:0] mem_data,
    output logic [15:0] result,
    output logic [15:0] overflow,
    output logic        out_valid,
    output logic [15:0] out_ins,
    output logic [15:0] out_pc,
    output logic [15:0] out_ra_val,
    output logic [15:0] out_rx_val,
    output logic [3:0]  out_rx
);

    logic  x_valid_r;
    word_t x_pc_r;
    word_t x_ins_r;
    word_t x_ra_r;
    word_t x_rx_val_r;

    logic  x2_valid_r;
    word_t x2_pc_r;
    word_t x2_ins_r;
    word_t x2_ra_r;
    word_t x2_rx_val_r;
    logic [3:0] x2_rx_r;
    word_t x2_result_r;
    word_t x2_overflow_r;

    word_t      alu_result_s;
    word_t      alu_overflow_s;
    logic [3:0] x_rx_s;

    alu_compute u_alu_compute (
        .ins      (x_ins_r),
        .a        (x_ra_r),
        .x        (x_rx_val_r),
        .result   (alu_result_s),
        .overflow (alu_overflow_s)
    );

    assign x_rx_s = uses_rb(x_ins_r[15:12]) ? x_ins_r[7:4] : x_ins_r[3:0];

    // Valid pipeline: flush kills whatever enters X and X2 on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_valid_r  <= 1'b0;
            x2_valid_r <= 1'b0;
        end else begin
            x_valid_r  <= in_valid & ~flush;
            x2_valid_r <= x_valid_r & ~flush;
        end
    end

    // X stage capture of the presented instruction and operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_pc_r     <= 16'hFFFF;
            x_ins_r    <= 16'h0000;
            x_ra_r     <= 16'h0000;
            x_rx_val_r <= 16'h0000;
        end else begin
            x_pc_r     <= in_pc;
            x_ins_r    <= in_ins;
            x_ra_r     <= ra_val;
            x_rx_val_r <= rx_val;
        end
    end

    // X2 stage capture of the ALU outputs and carried fields.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x2_pc_r       <= 16'hFFFF;
            x2_ins_r      <= 16'h0000;
            x2_ra_r       <= 16'h0000;
            x2_rx_val_r   <= 16'h0000;
            x2_rx_r       <= 4'h0;
            x2_result_r   <= 16'h0000;
            x2_overflow_r <= 16'h0000;
        end else begin
            x2_pc_r       <= x_pc_r;
            x2_ins_r      <= x_ins_r;
            x2_ra_r       <= x_ra_r;
            x2_rx_val_r   <= x_rx_val_r;
            x2_rx_r       <= x_rx_s;
            x2_result_r   <= alu_result_s;
            x2_overflow_r <= alu_overflow_s;
        end
    end

    assign result     = is_load(x2_ins_r) ? mem_data : x2_result_r;
    assign overflow   = x2_overflow_r;
    assign out_valid  = x2_valid_r;
    assign out_ins    = x2_ins_r;
    assign out_pc     = x2_pc_r;
    assign out_ra_val = x2_ra_r;
    assign out_rx_val = x2_rx_val_r;
    assign out_rx     = x2_rx_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors followed by randomized
// instructions, compared against an arithmetic reference model.
module tb_alu_pipe;

    localparam int N = 260;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_ins;
    logic [15:0] ra_val;
    logic [15:0] rx_val;
    logic [15:0] mem_data;
    logic [15:0] result;
    logic [15:0] overflow;
    logic        out_valid;
    logic [15:0] out_ins;
    logic [15:0] out_pc;
    logic [15:0] out_ra_val;
    logic [15:0] out_rx_val;
    logic [3:0]  out_rx;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] s_ins [N];
    logic [15:0] s_pc  [N];
    logic [15:0] s_a   [N];
    logic [15:0] s_x   [N];
    logic [15:0] s_md  [N];
    bit          s_vld [N];
    bit          s_fl  [N+2];
    bit          k_has [N];
    logic [15:0] k_res [N];
    logic [15:0] k_ovf [N];

    alu_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_ins     (in_ins),
        .ra_val     (ra_val),
        .rx_val     (rx_val),
        .mem_data   (mem_data),
        .result     (result),
        .overflow   (overflow),
        .out_valid  (out_valid),
        .out_ins    (out_ins),
        .out_pc     (out_pc),
        .out_ra_val (out_ra_val),
        .out_rx_val (out_rx_val),
        .out_rx     (out_rx)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference behaviour written straight from the opcode table.
    task automatic ref_model(input logic [15:0] ins, input logic [15:0] a, input logic [15:0] x,
                             input logic [15:0] md, output logic [15:0] r, output logic [15:0] o,
                             output logic [3:0] rx);
        int    op, sub, imm;
        longint ai, xi, p;
        bit    tk;
        op  = int'(ins[15:12]);
        sub = int'(ins[7:4]);
        imm = int'(ins[11:4]);
        ai  = longint'(a);
        xi  = longint'(x);
        r = 16'h0000;
        o = 16'h0000;
        if (op == 0 || op == 8) begin
            r = 16'((ai + xi) % 65536);
            o = (ai + xi >= 65536) ? 16'h0001 : 16'h0000;
        end else if (op == 1 || op == 9) begin
            r = 16'((ai - xi + 65536) % 65536);
            o = (ai < xi) ? 16'h0001 : 16'h0000;
        end else if (op == 2 || op == 10) begin
            p = ai * xi;
            r = 16'(p % 65536);
            o = 16'(p / 65536);
        end else if (op == 3 || op == 11) begin
            if (xi == 0) begin
                r = 16'hFFFF;
                o = a;
            end else begin
                r = 16'(ai / xi);
                o = 16'(ai % xi);
            end
        end else if (op == 4) begin
            r = (imm >= 128) ? 16'(imm + 65280) : 16'(imm);
        end else if (op == 5) begin
            r = 16'(imm * 256 + int'(xi % 256));
        end else if (op == 6) begin
            tk = (sub == 0) ? (xi == 0) :
                 (sub == 1) ? (xi != 0) :
                 (sub == 2) ? (xi >= 32768) :
                 (sub == 3) ? (xi < 32768) : 1'b0;
            r = a;
            o = tk ? 16'h0001 : 16'h0000;
        end else if (op == 7 || op == 12 || op == 13) begin
            if (sub == 0) begin
                r = md;
            end else if (sub == 1) begin
                r = x;
                o = a;
            end
        end else if (op == 14) begin
            r = 16'((ai * xi) % 65536);
        end
        if (op <= 3 || (op >= 8 && op <= 11) || op == 14) rx = ins[7:4];
        else rx = ins[3:0];
    endtask

    task automatic check_entry(input int k);
        logic [15:0] r, o;
        logic [3:0]  rx;
        bit          ev;
        ev = s_vld[k] && !s_fl[k] && !s_fl[k+1];
        check_value($sformatf("valid[%0d]", k), 32'(out_valid), 32'(ev));
        if (ev) begin
            ref_model(s_ins[k], s_a[k], s_x[k], s_md[k], r, o, rx);
            check_value($sformatf("result[%0d]", k),   32'(result),     32'(r));
            check_value($sformatf("overflow[%0d]", k), 32'(overflow),   32'(o));
            check_value($sformatf("ins[%0d]", k),      32'(out_ins),    32'(s_ins[k]));
            check_value($sformatf("pc[%0d]", k),       32'(out_pc),     32'(s_pc[k]));
            check_value($sformatf("ra[%0d]", k),       32'(out_ra_val), 32'(s_a[k]));
            check_value($sformatf("rxval[%0d]", k),    32'(out_rx_val), 32'(s_x[k]));
            check_value($sformatf("rx[%0d]", k),       32'(out_rx),     32'(rx));
            if (k_has[k]) begin
                check_value($sformatf("kres[%0d]", k), 32'(result),   32'(k_res[k]));
                check_value($sformatf("kovf[%0d]", k), 32'(overflow), 32'(k_ovf[k]));
            end
        end
    endtask

    task automatic put(input int i, input logic [15:0] ins, input logic [15:0] a,
                       input logic [15:0] x, input logic [15:0] md, input bit has,
                       input logic [15:0] kr, input logic [15:0] ko);
        s_ins[i] = ins;  s_a[i] = a;  s_x[i] = x;  s_md[i] = md;
        s_pc[i]  = 16'(16'h0100 + i * 2);
        s_vld[i] = 1'b1; s_fl[i] = 1'b0;
        k_has[i] = has;  k_res[i] = kr; k_ovf[i] = ko;
    endtask

    initial begin
        // Directed vectors with hand-derived expectations.
        put(0,  16'h0123, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 16'h0000, 16'h0001);
        put(1,  16'h2123, 16'h1234, 16'h0100, 16'h0000, 1'b1, 16'h3400, 16'h0012);
        put(2,  16'h3123, 16'h0007, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0007);
        put(3,  16'h3123, 16'h0007, 16'h0002, 16'h0000, 1'b1, 16'h0003, 16'h0001);
        put(4,  16'h4FF3, 16'h1111, 16'h2222, 16'h0000, 1'b1, 16'hFFFF, 16'h0000);
        put(5,  16'h5AB3, 16'h1111, 16'h00CD, 16'h0000, 1'b1, 16'hABCD, 16'h0000);
        put(6,  16'h6103, 16'h0040, 16'h0000, 16'h0000, 1'b1, 16'h0040, 16'h0001);
        put(7,  16'h6103, 16'h0040, 16'h0005, 16'h0000, 1'b1, 16'h0040, 16'h0000);
        put(8,  16'h7103, 16'h0020, 16'h0030, 16'hBEEF, 1'b1, 16'hBEEF, 16'h0000);
        put(9,  16'h1000, 16'h0000, 16'h0001, 16'h0000, 1'b1, 16'hFFFF, 16'h0001);
        // Back-to-back valids; flush on the second kills both in flight.
        put(10, 16'h0012, 16'h0001, 16'h0002, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        put(11, 16'h0034, 16'h0003, 16'h0004, 16'h0000, 1'b0, 16'h0000, 16'h0000);
        put(12, 16'h0056, 16'h0005, 16'h0006, 16'h0000, 1'b1, 16'h000B, 16'h0000);
        s_fl[11] = 1'b1;
        for (int i = 13; i < N; i++) begin
            s_ins[i] = 16'($urandom);
            s_pc[i]  = 16'($urandom);
            s_a[i]   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            s_x[i]   = ($urandom_range(0, 7) == 0) ? 16'h0000 :
                       ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            s_md[i]  = 16'($urandom);
            s_vld[i] = ($urandom_range(0, 7) != 0);
            s_fl[i]  = (i >= 14) && ($urandom_range(0, 15) == 0);
            k_has[i] = 1'b0; k_res[i] = 16'h0000; k_ovf[i] = 16'h0000;
        end
        s_fl[N] = 1'b0;
        s_fl[N+1] = 1'b0;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_pc = 16'h0000;
        in_ins = 16'h0000; ra_val = 16'h0000; rx_val = 16'h0000; mem_data = 16'h0000;
        #12;
        check_value("rst_valid",    32'(out_valid), 32'h0);
        check_value("rst_pc",       32'(out_pc),    32'hFFFF);
        check_value("rst_result",   32'(result),    32'h0);
        check_value("rst_overflow", 32'(overflow),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < N + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                mem_data = s_md[i-2];
                #1;
                check_entry(i - 2);
            end
            if (i < N) begin
                in_valid = s_vld[i]; in_ins = s_ins[i]; in_pc = s_pc[i];
                ra_val = s_a[i]; rx_val = s_x[i];
            end else begin
                in_valid = 1'b0; in_ins = 16'h0000; in_pc = 16'h0000;
                ra_val = 16'h0000; rx_val = 16'h0000;
            end
            flush = s_fl[i];
        end

        // Asynchronous reset in the middle of a valid stream.
        @(negedge clk);
        in_valid = 1'b1; in_ins = 16'h0123; in_pc = 16'h0ABC;
        ra_val = 16'h0001; rx_val = 16'h0001; flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check_value("pre_rst_valid", 32'(out_valid), 32'h1);
        check_value("pre_rst_pc",    32'(out_pc),    32'h0ABC);
        #1;
        rst_n = 1'b0;
        #1;
        check_value("async_rst_valid", 32'(out_valid), 32'h0);
        check_value("async_rst_pc",    32'(out_pc),    32'hFFFF);
        check_value("async_rst_res",   32'(result),    32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
